// File: rtl/a0_trace_pkg.sv
// Shared types and constants for the a0 trace capture stage.
package a0_trace_pkg;

  localparam int unsigned DefaultTsW = 32;
  localparam int unsigned ValW       = 32;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef struct packed {
    logic [ValW-1:0]       val;
    logic [DefaultTsW-1:0] ts;
  } trace_entry_t;

endpackage

// File: rtl/a0_trace_fifo_if.sv
// Read-side valid/ready handshake carrying one timestamped a0 value per transfer.
interface a0_trace_fifo_if
  import a0_trace_pkg::*;
#(
  parameter int unsigned TS_W = DefaultTsW
);

  logic            rd_valid;
  logic            rd_ready;
  logic [ValW-1:0] rd_data;
  logic [TS_W-1:0] rd_ts;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_ts,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_ts,
    output rd_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a pop in the same cycle frees a slot for a push when full.
module sync_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i & ~empty_o;
    push_ok  = push_i & (~full_o | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointer overflow is the wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/a0_trace_fifo.sv
// Timestamps every change of the CPU a0 bus and queues it for a slower downstream consumer.
module a0_trace_fifo
  import a0_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = DefaultTsW,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ValW-1:0]    a0,
  input  logic               capture_en,
  a0_trace_fifo_if.master    rd,
  output logic [CntW-1:0]    count,
  output logic               overflow,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned EntryW = ValW + TS_W;

  logic [TS_W-1:0]   cyc_q;
  logic [ValW-1:0]   prev_a0_q;
  logic              overflow_q;
  logic [7:0]        drop_cnt_q;

  logic              chg, pop, drop;
  logic              full, empty;
  logic [EntryW-1:0] wdata, rdata;

  assign chg   = (a0 != prev_a0_q) & capture_en;
  assign pop   = rd.rd_valid & rd.rd_ready;
  // A same-cycle pop makes room, so only a full FIFO without a pop loses the change.
  assign drop  = chg & full & ~pop;
  assign wdata = {a0, cyc_q};

  sync_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (chg),
    .wdata_i (wdata),
    .pop_i   (rd.rd_ready),
    .rdata_o (rdata),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rd.rd_valid = ~empty;
  assign rd.rd_data  = rdata[TS_W +: ValW];
  assign rd.rd_ts    = rdata[TS_W-1:0];

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      prev_a0_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      cyc_q     <= cyc_q + TS_W'(1);
      prev_a0_q <= a0;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != DROP_MAX) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed bench for a0_trace_fifo with a queue scoreboard checked on every handshake.
module tb_a0_trace_fifo;
  import a0_trace_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a0 = '0;
  logic        capture_en = 1'b1;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  a0_trace_fifo_if #(.TS_W(TS_W)) rd ();

  a0_trace_fifo #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a0         (a0),
    .capture_en (capture_en),
    .rd         (rd),
    .count      (count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  trace_entry_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_m    = 0;  // value of the DUT cycle counter during the current cycle
  int first_ts;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted transfer must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    trace_entry_t e;
    if (!rst && rd.rd_valid === 1'b1 && rd.rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got data 0x%0h ts 0x%0h, expected no entry",
                 rd.rd_data, rd.rd_ts);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rd_data", 64'(rd.rd_data), 64'(e.val));
        chk("sb_rd_ts", 64'(rd.rd_ts), 64'(e.ts));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_m++;
  endtask

  task automatic set_a0(input logic [31:0] v, input bit exp_push);
    a0 = v;
    if (exp_push) exp_q.push_back(trace_entry_t'{val: v, ts: TS_W'(cyc_m)});
    tick();
  endtask

  // One reset cycle; a0 takes v as rst releases, so a change hits the first post-reset edge.
  task automatic do_reset(input logic [31:0] v, input bit exp_push);
    rst = 1'b1;
    tick();
    exp_q.delete();
    rst   = 1'b0;
    cyc_m = 0;
    a0    = v;
    if (exp_push) exp_q.push_back(trace_entry_t'{val: v, ts: TS_W'(0)});
  endtask

  task automatic drain(input int n);
    rd.rd_ready = 1'b1;
    repeat (n) tick();
    rd.rd_ready = 1'b0;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rd.rd_ready = 1'b0;

    // a0 stuck at 0 after reset: nothing captured
    do_reset(32'd0, 1'b0);
    repeat (10) tick();
    chk("idle_rd_valid", 64'(rd.rd_valid), 64'd0);
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_overflow", 64'(overflow), 64'd0);
    chk("idle_drop_cnt", 64'(drop_cnt), 64'd0);

    // 0 -> 5 while cyc = 3
    do_reset(32'd0, 1'b0);
    repeat (3) tick();
    rd.rd_ready = 1'b1;
    set_a0(32'd5, 1'b1);
    chk("step_rd_valid", 64'(rd.rd_valid), 64'd1);
    chk("step_rd_data", 64'(rd.rd_data), 64'd5);
    chk("step_rd_ts", 64'(rd.rd_ts), 64'd3);
    tick();
    rd.rd_ready = 1'b0;
    chk("step_count_after_pop", 64'(count), 64'd0);
    chk("step_rd_valid_after_pop", 64'(rd.rd_valid), 64'd0);

    // 20 changes into a 16-entry FIFO with no consumer
    first_ts = cyc_m;
    for (int i = 0; i < 20; i++) set_a0(32'd100 + 32'(i), i < 16);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_overflow", 64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("ovf_head_data", 64'(rd.rd_data), 64'd100);
    chk("ovf_head_ts", 64'(rd.rd_ts), 64'(first_ts));
    repeat (2) tick();
    chk("ovf_head_stable", 64'(rd.rd_data), 64'd100);
    drain(16);
    chk("ovf_count_drained", 64'(count), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // full FIFO, change plus pop in the same cycle
    for (int i = 0; i < 16; i++) set_a0(32'd200 + 32'(i), 1'b1);
    chk("fullpop_count_before", 64'(count), 64'd16);
    rd.rd_ready = 1'b1;
    set_a0(32'd216, 1'b1);
    rd.rd_ready = 1'b0;
    chk("fullpop_count", 64'(count), 64'd16);
    chk("fullpop_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("fullpop_new_head", 64'(rd.rd_data), 64'd201);
    drain(16);
    chk("fullpop_count_drained", 64'(count), 64'd0);

    // changes while capture is disabled are not replayed
    capture_en = 1'b0;
    set_a0(32'd1, 1'b0);
    set_a0(32'd2, 1'b0);
    set_a0(32'd3, 1'b0);
    capture_en = 1'b1;
    repeat (3) tick();
    chk("gate_count", 64'(count), 64'd0);
    chk("gate_rd_valid", 64'(rd.rd_valid), 64'd0);
    set_a0(32'd4, 1'b1);
    chk("gate_count_after", 64'(count), 64'd1);
    chk("gate_rd_data", 64'(rd.rd_data), 64'd4);
    drain(1);
    chk("gate_count_drained", 64'(count), 64'd0);

    // reset mid-operation discards contents and restarts the timestamp
    for (int i = 0; i < 7; i++) set_a0(32'd300 + 32'(i), 1'b1);
    chk("rst_count_before", 64'(count), 64'd7);
    do_reset(32'd400, 1'b1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd_valid", 64'(rd.rd_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    tick();
    chk("rst_first_valid", 64'(rd.rd_valid), 64'd1);
    chk("rst_first_data", 64'(rd.rd_data), 64'd400);
    chk("rst_first_ts", 64'(rd.rd_ts), 64'd0);
    drain(1);
    chk("rst_count_drained", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
